ask_frame_rx: RTL and testbench

//  Receive front end ahead of the Hamming decoder. Slices 8-bit ADC envelope samples into line

---
 rtl/ask_frame_rx.sv | 218 +++++++++++++++++++++
 tb/tb_ask_frame_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ask_frame_rx.sv
// ============================================================================
// ask_frame_rx
// ----------------------------------------------------------------------------
// Receive front end that sits ahead of the Hamming decoder.
//   * Slices 8-bit unsigned ADC envelope samples into a line level, with
//     hysteresis between TH_LO and TH_HI.
//   * Locks onto a start bit and confirms it at mid-symbol.
//   * Shifts in one 8-bit codeword, MSB first.
//   * Checks the stop bit, then hands the codeword to the decoder together
//     with a one-cycle valid strobe.
// One ADC sample arrives per clk_slow cycle.
//
// Frame on the line: idle 0, start 1, d7..d0, stop 0. Each bit lasts SPS
// samples.
//
// Parameters
//   SPS    samples per symbol (even, >= 4)
//   TH_HI  sample >= TH_HI slices to 1
//   TH_LO  sample <= TH_LO slices to 0 (TH_LO < TH_HI); in between, hold
//
// Ports
//   clk_slow    in   sample clock, rising edge
//   reset       in   asynchronous, active-low
//   adc_data    in   [7:0] unsigned envelope sample
//   code_word   out  [7:0] last good codeword, held until the next good frame
//   code_valid  out  one-cycle strobe: code_word has just been updated
//   frame_err   out  one-cycle strobe: the stop bit was bad
//   busy        out  high while in START, DATA or STOP
//   sliced      out  registered slicer output
//
// Build option
//   RX_MAJORITY_EN  When defined, each data bit and the stop bit are decided
//                   by a 2-of-3 majority of sliced at cnt = SPS-3, SPS-2 and
//                   SPS-1. The start-bit check stays a single sample.
//                   When undefined, each bit is sliced at cnt == SPS-1 and no
//                   vote registers exist.
// ============================================================================
module ask_frame_rx #(
    parameter int unsigned SPS   = 8,
    parameter logic [7:0]  TH_HI = 8'd160,
    parameter logic [7:0]  TH_LO = 8'd96
) (
    input  logic       clk_slow,
    input  logic       reset,
    input  logic [7:0] adc_data,
    output logic [7:0] code_word,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       sliced
);

    localparam int unsigned      CNT_W    = $clog2(SPS);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SPS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bidx;
    logic [7:0]       shreg;
    logic             sliced_d;
    logic             bit_val;

    // ------------------------------------------------------------------------
    // Slicer stage: hysteresis comparator followed by a one-cycle delay, which
    // the rising-edge detector in IDLE uses.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_slow or negedge reset) begin
        if (!reset) begin
            sliced   <= 1'b0;
            sliced_d <= 1'b0;
        end else begin
            if (adc_data >= TH_HI) begin
                sliced <= 1'b1;
            end else if (adc_data <= TH_LO) begin
                sliced <= 1'b0;
            end
            sliced_d <= sliced;
        end
    end

`ifdef RX_MAJORITY_EN
    logic vote_p0;
    logic vote_p1;

    localparam logic [CNT_W-1:0] CNT_V0 = CNT_W'(SPS - 3);
    localparam logic [CNT_W-1:0] CNT_V1 = CNT_W'(SPS - 2);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ------------------------------------------------------------------------
    // Vote stage: hold the two earlier samples of the current symbol. The
    // third vote is the live slicer output at cnt == SPS-1.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_slow or negedge reset) begin
        if (!reset) begin
            vote_p0 <= 1'b0;
            vote_p1 <= 1'b0;
        end else if (state == S_DATA || state == S_STOP) begin
            if (cnt == CNT_V0) begin
                vote_p0 <= sliced;
            end
            if (cnt == CNT_V1) begin
                vote_p1 <= sliced;
            end
        end
    end

    assign bit_val = maj3(vote_p0, vote_p1, sliced);
`else
    assign bit_val = sliced;
`endif

    // ------------------------------------------------------------------------
    // Frame FSM. All outputs are registered here.
    // The strobes default low, so each one lasts exactly one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_slow or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bidx       <= '0;
            shreg      <= '0;
            code_word  <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!sliced_d && sliced) begin
                        state <= S_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                // Confirm the start bit at mid-symbol. This check also places
                // every later bit decision at mid-symbol.
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (sliced) begin
                            state <= S_DATA;
                            bidx  <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {shreg[6:0], bit_val};
                        if (bidx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bidx <= bidx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt  <= '0;
                        busy <= 1'b0;
                        if (!bit_val) begin
                            code_word  <= shreg;
                            code_valid <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A line stuck high after a bad stop bit must drop to 0 first.
                // Only then can the edge detector see a new start.
                S_BREAK: begin
                    if (!sliced) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The two strobes come from mutually exclusive branches of the stop decision.
    assert property (@(posedge clk_slow) disable iff (!reset) !(code_valid && frame_err));

endmodule

// File: tb/tb_ask_frame_rx.sv
module tb_ask_frame_rx;

    localparam int         SPS  = 8;
    localparam logic [7:0] LVL1 = 8'd200;
    localparam logic [7:0] LVL0 = 8'd20;

    logic       clk_slow;
    logic       reset;
    logic [7:0] adc_data;
    logic [7:0] code_word;
    logic       code_valid;
    logic       frame_err;
    logic       busy;
    logic       sliced;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor-owned event counters.
    int cv_cnt    = 0;
    int fe_cnt    = 0;
    int busy_cnt  = 0;
    int sl_cnt    = 0;
    int both_cnt  = 0;
    int cv_edge   = 0;
    int prev_cw   = 0;
    int last_cw   = 0;

    int edge_n      = 0;
    int frame_start = 0;

    ask_frame_rx #(
        .SPS   (SPS),
        .TH_HI (8'd160),
        .TH_LO (8'd96)
    ) dut (
        .clk_slow   (clk_slow),
        .reset      (reset),
        .adc_data   (adc_data),
        .code_word  (code_word),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .sliced     (sliced)
    );

    initial begin
        clk_slow = 1'b0;
        forever #5 clk_slow = ~clk_slow;
    end

    always @(negedge clk_slow) begin
        if (code_valid) begin
            cv_cnt  = cv_cnt + 1;
            cv_edge = edge_n;
            prev_cw = last_cw;
            last_cw = int'(code_word);
        end
        if (frame_err)              fe_cnt   = fe_cnt + 1;
        if (busy)                   busy_cnt = busy_cnt + 1;
        if (sliced)                 sl_cnt   = sl_cnt + 1;
        if (code_valid && frame_err) both_cnt = both_cnt + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_sample(input logic [7:0] v);
        adc_data = v;
        @(posedge clk_slow);
        #1;
        edge_n++;
    endtask

    task automatic send_level(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_sample(v);
    endtask

    // Sample index SPS/2 of a symbol is the one the slicer presents at
    // cnt == SPS-1. The corrupt option replaces that sample with a 0 level.
    task automatic send_bit(input logic b, input bit corrupt);
        for (int i = 0; i < SPS; i++) begin
            if (corrupt && i == SPS / 2) send_sample(LVL0);
            else                         send_sample(b ? LVL1 : LVL0);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input bit corrupt);
        send_sample(LVL1);
        frame_start = edge_n;
        send_level(LVL1, SPS - 1);
        for (int k = 7; k >= 0; k--) send_bit(data[k], corrupt);
        send_bit(stop_bit, corrupt);
    endtask

    int cv0, fe0, bz0, sl0;
    int exp_corrupt;

    initial begin
        reset    = 1'b0;
        adc_data = LVL0;
        repeat (3) @(posedge clk_slow);
        #1;
        // Reset state
        check_val("rst_code_word", int'(code_word), 0);
        check_val("rst_code_valid", int'(code_valid), 0);
        check_val("rst_frame_err", int'(frame_err), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_sliced", int'(sliced), 0);
        reset = 1'b1;
        send_level(LVL0, 4);

        // Test 1: reset in the middle of a frame
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_level(LVL1, SPS);
        send_level(LVL0, 12);
        check_val("mid_busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_sliced", int'(sliced), 0);
        check_val("mid_rst_code_word", int'(code_word), 0);
        adc_data = LVL0;
        @(posedge clk_slow);
        @(posedge clk_slow);
        #2;
        reset = 1'b1;
        send_level(LVL0, 100);
        check_val("mid_no_valid", cv_cnt - cv0, 0);
        check_val("mid_no_err", fe_cnt - fe0, 0);

        // Test 2: clean 0xA5 frame
        cv0 = cv_cnt; fe0 = fe_cnt; bz0 = busy_cnt;
        send_frame(8'hA5, 1'b0, 1'b0);
        send_level(LVL0, 8);
        check_val("a5_code_word", int'(code_word), 32'hA5);
        check_val("a5_valid_count", cv_cnt - cv0, 1);
        check_val("a5_latency", cv_edge - frame_start, 77);
        check_val("a5_err_count", fe_cnt - fe0, 0);
        check_val("a5_busy_cycles", busy_cnt - bz0, 76);
        check_val("a5_busy_end", int'(busy), 0);

        // Test 3: 0x3C with the stop bit held at 1
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        bz0 = busy_cnt;
        send_level(LVL1, 16);
        check_val("3c_err_count", fe_cnt - fe0, 1);
        check_val("3c_valid_count", cv_cnt - cv0, 0);
        check_val("3c_code_word_kept", int'(code_word), 32'hA5);
        check_val("3c_no_rearm_busy", busy_cnt - bz0, 0);
        send_level(LVL0, 4);
        // Rearmed: back-to-back frames 0x81 then 0x7E
        cv0 = cv_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0);
        send_level(LVL0, 8);
        check_val("b2b_valid_count", cv_cnt - cv0, 2);
        check_val("b2b_first_word", prev_cw, 32'h81);
        check_val("b2b_second_word", int'(code_word), 32'h7E);

        // Test 4: 2-sample glitch on the idle line
        cv0 = cv_cnt; fe0 = fe_cnt; bz0 = busy_cnt;
        send_level(LVL1, 2);
        send_level(LVL0, 12);
        check_val("glitch_busy_cycles", busy_cnt - bz0, 4);
        check_val("glitch_no_valid", cv_cnt - cv0, 0);
        check_val("glitch_no_err", fe_cnt - fe0, 0);

        // Test 5: samples inside the hysteresis band after line 0
        sl0 = sl_cnt; bz0 = busy_cnt;
        for (int i = 0; i < 20; i++) send_sample((i % 2 == 0) ? 8'd150 : 8'd110);
        check_val("band_sliced_high", sl_cnt - sl0, 0);
        check_val("band_busy", busy_cnt - bz0, 0);

        // Threshold edges: 159 holds, 160 sets, 97 holds, 96 clears
        send_sample(8'd159);
        check_val("thr_159", int'(sliced), 0);
        send_sample(8'd160);
        check_val("thr_160", int'(sliced), 1);
        send_sample(8'd97);
        check_val("thr_97", int'(sliced), 1);
        send_sample(8'd96);
        check_val("thr_96", int'(sliced), 0);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_level(LVL0, 10);
        check_val("thr_no_valid", cv_cnt - cv0, 0);
        check_val("thr_no_err", fe_cnt - fe0, 0);

        // Test 6: 0xFF with one corrupted sample in every symbol
`ifdef RX_MAJORITY_EN
        exp_corrupt = 32'hFF;
`else
        exp_corrupt = 32'h00;
`endif
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'hFF, 1'b0, 1'b1);
        send_level(LVL0, 8);
        check_val("corrupt_code_word", int'(code_word), exp_corrupt);
        check_val("corrupt_valid_count", cv_cnt - cv0, 1);
        check_val("corrupt_err_count", fe_cnt - fe0, 0);

        check_val("strobes_never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
